// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared types and screen geometry for the doodle sprite logic
package doodle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } motion_state_t;

    typedef logic signed [3:0] delta_t;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;

    // Opposing keys cancel rather than prioritising one side.
    function automatic delta_t steer(input logic left, input logic right, input int step);
        delta_t d;
        d = 4'sd0;
        if (left && !right) begin
            d = 4'(-step);
        end else if (right && !left) begin
            d = 4'(step);
        end
        return d;
    endfunction

endpackage

// File: rtl/doodle_motion_controller_sync_edge_detect.sv
// rtl/doodle_motion_controller_sync_edge_detect.sv - two-flop synchroniser with rising-edge pulse
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise_pulse
);

    logic q1_q, q1_d;
    logic q2_q, q2_d;

    always_comb begin
        q1_d = sig_in;
        q2_d = q1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

    assign rise_pulse = q1_q & ~q2_q;

endmodule

// File: rtl/doodle_motion_controller.sv
// rtl/doodle_motion_controller.sv - per-frame jump/fall sequencer, gravity, steering and sprite position
module doodle_motion_controller
    import doodle_pkg::*;
#(
    parameter int SCREEN_W    = doodle_pkg::SCREEN_W,
    parameter int SCREEN_H    = doodle_pkg::SCREEN_H,
    parameter int SPRITE_H    = 40,
    parameter int START_X     = 380,
    parameter int START_Y     = 500,
    parameter int JUMP_V      = 7,
    parameter int GRAVITY_DIV = 4,
    parameter int STEP_X      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_sync,
    input  logic               start,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               platform_hit,
    output logic signed [3:0]  delta_x,
    output logic signed [3:0]  delta_y,
    output logic [10:0]        doodle_x,
    output logic [9:0]         doodle_y,
    output motion_state_t      state,
    output logic               update_done
);

    localparam logic signed [3:0]  VY_LAUNCH = 4'(-JUMP_V);
    localparam logic signed [3:0]  VY_MAX    = 4'sd7;
    localparam logic [7:0]         CNT_LAST  = 8'(GRAVITY_DIV - 1);
    localparam logic signed [11:0] W12       = 12'(SCREEN_W);
    localparam logic signed [11:0] H12       = 12'(SCREEN_H);
    localparam logic signed [11:0] SPR12     = 12'(SPRITE_H);

    logic frame_edge;

    motion_state_t     state_q, state_d;
    logic signed [3:0] vy_q, vy_d;
    logic [7:0]        cnt_q, cnt_d;
    logic signed [3:0] dx_q, dx_d;
    logic signed [3:0] dy_q, dy_d;
    logic [10:0]       x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              done_q, done_d;
    logic              upd_q, upd_d;

    delta_t             steer_dx;
    logic signed [11:0] x_sum, x_wrap;
    logic signed [10:0] y_sum;
    logic signed [11:0] foot;
    logic [9:0]         y_clamped;
    logic signed [3:0]  vy_grav;
    logic [7:0]         cnt_grav;
    logic               hits_floor;

    sync_edge_detect u_frame_edge (
        .clk        (clk),
        .rst_n      (rst),
        .sig_in     (frame_sync),
        .rise_pulse (frame_edge)
    );

    always_comb begin
        state_d = state_q;
        vy_d    = vy_q;
        cnt_d   = cnt_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;

        // Edges seen outside RISE/FALL never become updates, which also drops
        // an edge that coincides with a start pulse.
        upd_d = frame_edge && (state_q == RISE || state_q == FALL);

        steer_dx = steer(move_left, move_right, STEP_X);
        x_sum    = $signed({1'b0, x_q}) + 12'(steer_dx);
        if (x_sum < 12'sd0) begin
            x_wrap = x_sum + W12;
        end else if (x_sum >= W12) begin
            x_wrap = x_sum - W12;
        end else begin
            x_wrap = x_sum;
        end

        y_sum      = $signed({1'b0, y_q}) + 11'(vy_q);
        y_clamped  = (y_sum < 11'sd0) ? 10'd0 : y_sum[9:0];
        foot       = $signed({y_sum[10], y_sum}) + SPR12;
        hits_floor = (foot >= H12);

        if (cnt_q == CNT_LAST) begin
            cnt_grav = 8'd0;
            vy_grav  = (vy_q == VY_MAX) ? VY_MAX : vy_q + 4'sd1;
        end else begin
            cnt_grav = cnt_q + 8'd1;
            vy_grav  = vy_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RISE;
                    vy_d    = VY_LAUNCH;
                    cnt_d   = 8'd0;
                end
            end
            DEAD: begin
                if (start) begin
                    state_d = RISE;
                    vy_d    = VY_LAUNCH;
                    cnt_d   = 8'd0;
                    x_d     = 11'(START_X);
                    y_d     = 10'(START_Y);
                end
            end
            RISE, FALL: begin
                if (upd_q) begin
                    done_d = 1'b1;
                    dx_d   = steer_dx;
                    dy_d   = vy_q;
                    x_d    = x_wrap[10:0];
                    if (platform_hit && vy_q > 4'sd0) begin
                        state_d = RISE;
                        vy_d    = VY_LAUNCH;
                        cnt_d   = 8'd0;
                        y_d     = y_clamped;
                    end else if (state_q == FALL && hits_floor) begin
                        state_d = DEAD;
                        dx_d    = 4'sd0;
                        dy_d    = 4'sd0;
                        x_d     = x_q;
                    end else begin
                        y_d   = y_clamped;
                        vy_d  = vy_grav;
                        cnt_d = cnt_grav;
                        if (state_q == RISE && vy_grav >= 4'sd0) begin
                            state_d = FALL;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            vy_q    <= 4'sd0;
            cnt_q   <= 8'd0;
            dx_q    <= 4'sd0;
            dy_q    <= 4'sd0;
            x_q     <= 11'(START_X);
            y_q     <= 10'(START_Y);
            done_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vy_q    <= vy_d;
            cnt_q   <= cnt_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
            upd_q   <= upd_d;
        end
    end

    assign delta_x     = dx_q;
    assign delta_y     = dy_q;
    assign doodle_x    = x_q;
    assign doodle_y    = y_q;
    assign state       = state_q;
    assign update_done = done_q;

endmodule

// File: tb/tb_doodle_motion_controller.sv
// tb/tb_doodle_motion_controller.sv - directed scoreboard bench for doodle_motion_controller
module tb_doodle_motion_controller;
    import doodle_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_sync = 1'b0;
    logic              start = 1'b0;
    logic              move_left = 1'b0;
    logic              move_right = 1'b0;
    logic              platform_hit = 1'b0;
    logic signed [3:0] delta_x;
    logic signed [3:0] delta_y;
    logic [10:0]       doodle_x;
    logic [9:0]        doodle_y;
    motion_state_t     state;
    logic              update_done;

    always #5 clk = ~clk;

    doodle_motion_controller dut (
        .clk          (clk),
        .rst          (rst),
        .frame_sync   (frame_sync),
        .start        (start),
        .move_left    (move_left),
        .move_right   (move_right),
        .platform_hit (platform_hit),
        .delta_x      (delta_x),
        .delta_y      (delta_y),
        .doodle_x     (doodle_x),
        .doodle_y     (doodle_y),
        .state        (state),
        .update_done  (update_done)
    );

    typedef struct {
        logic signed [3:0] dx;
        logic signed [3:0] dy;
        logic [10:0]       x;
        logic [9:0]        y;
        motion_state_t     st;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    motion_state_t m_st;
    int m_vy, m_cnt, m_x, m_y;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_st = IDLE; m_vy = 0; m_cnt = 0; m_x = 380; m_y = 500;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_st == IDLE || m_st == DEAD) begin
            if (m_st == DEAD) begin
                m_x = 380; m_y = 500;
            end
            m_st = RISE; m_vy = -7; m_cnt = 0;
        end
    endtask

    // Model one frame per the behavioural description, drive it, then score the DUT.
    task automatic frame(input logic hit, input logic l, input logic r);
        exp_t e;
        int dx, dy, nx, lat, spurious;
        bit active;
        platform_hit = hit; move_left = l; move_right = r;
        active = (m_st == RISE || m_st == FALL);
        if (active) begin
            dx = (l && !r) ? -3 : ((r && !l) ? 3 : 0);
            nx = m_x + dx;
            if (nx < 0) nx = nx + 800;
            else if (nx >= 800) nx = nx - 800;
            dy = m_vy;
            if (hit && m_vy > 0) begin
                m_vy = -7; m_cnt = 0; m_st = RISE; m_x = nx;
                m_y = (m_y + dy < 0) ? 0 : m_y + dy;
            end else if (m_st == FALL && m_y + dy + 40 >= 600) begin
                m_st = DEAD; dx = 0; dy = 0;
            end else begin
                m_x = nx;
                m_y = (m_y + dy < 0) ? 0 : m_y + dy;
                if (m_cnt == 3) begin
                    m_cnt = 0;
                    if (m_vy < 7) m_vy++;
                end else begin
                    m_cnt++;
                end
                if (m_st == RISE && m_vy >= 0) m_st = FALL;
            end
            e.dx = 4'(dx); e.dy = 4'(dy); e.x = 11'(m_x); e.y = 10'(m_y); e.st = m_st;
            sb.push_back(e);
        end
        frame_sync = 1'b1;
        if (active) begin
            lat = 0;
            while (!update_done && lat < 8) begin
                tick();
                lat++;
            end
            check("latency", lat, 3);
            if (update_done && sb.size() > 0) begin
                e = sb.pop_front();
                check("delta_x", delta_x, e.dx);
                check("delta_y", delta_y, e.dy);
                check("doodle_x", doodle_x, e.x);
                check("doodle_y", doodle_y, e.y);
                check("state", state, e.st);
            end
            tick();
            check("done_width", update_done, 0);
        end else begin
            spurious = 0;
            repeat (6) begin
                tick();
                if (update_done) spurious++;
            end
            check("no_update", spurious, 0);
            check("idle_dx", delta_x, 0);
            check("idle_dy", delta_y, 0);
        end
        frame_sync = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, spurious;
        model_reset();
        repeat (3) tick();
        check("rst_state", state, IDLE);
        check("rst_dx", delta_x, 0);
        check("rst_dy", delta_y, 0);
        check("rst_x", doodle_x, 380);
        check("rst_y", doodle_y, 500);
        check("rst_done", update_done, 0);
        rst = 1'b1;
        tick();

        frame(0, 0, 0);
        check("idle_hold_state", state, IDLE);

        pulse_start();
        check("launch_state", state, RISE);
        frame(0, 0, 0);
        check("launch_dy", delta_y, -7);
        check("launch_y", doodle_y, 493);

        for (int f = 2; f <= 28; f++) begin
            frame(0, 0, 0);
            check("gravity_dy", delta_y, -7 + (f - 1) / 4);
            check("gravity_state", state, (f == 28) ? FALL : RISE);
        end

        repeat (8) frame(0, 0, 0);
        frame(1, 0, 0);
        check("bounce_dy", delta_y, 2);
        check("bounce_state", state, RISE);
        frame(0, 0, 0);
        check("after_bounce_dy", delta_y, -7);

        // Asynchronous reset in the middle of a frame update.
        frame_sync = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_x", doodle_x, 380);
        check("midrst_y", doodle_y, 500);
        check("midrst_dy", delta_y, 0);
        tick();
        check("midrst_state", state, IDLE);
        spurious = 0;
        repeat (4) begin
            tick();
            if (update_done) spurious++;
        end
        check("midrst_no_done", spurious, 0);
        frame_sync = 1'b0;
        model_reset();
        rst = 1'b1;
        repeat (2) tick();
        frame(0, 0, 0);
        check("postrst_state", state, IDLE);

        // Steer left with platforms underfoot until the sprite sits at x=1.
        pulse_start();
        n = 0;
        while (m_x != 1 && n < 500) begin
            frame(1, 1, 0);
            n++;
        end
        check("wrap_at_1", doodle_x, 1);
        frame(1, 1, 0);
        check("wrap_dx", delta_x, -3);
        check("wrap_x", doodle_x, 798);
        frame(1, 1, 1);
        check("both_keys_dx", delta_x, 0);
        check("both_keys_x", doodle_x, 798);

        n = 0;
        while (m_st != DEAD && n < 300) begin
            frame(0, 0, 0);
            n++;
        end
        check("dead_state", state, DEAD);
        check("dead_dy", delta_y, 0);
        frame(0, 0, 0);
        check("dead_hold", state, DEAD);

        pulse_start();
        check("restart_x", doodle_x, 380);
        check("restart_y", doodle_y, 500);
        check("restart_state", state, RISE);
        frame(0, 0, 1);
        check("restart_dy", delta_y, -7);
        check("restart_dx", delta_x, 3);
        check("restart_new_x", doodle_x, 383);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
